// File: rtl/ysyx_23060124_pkg.sv
// Shared types and defaults for the ysyx_23060124 write-back unit.
// Holds FSM encoding, instruction-class flag bundle and reset constants.
package ysyx_23060124_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h3000_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_HOLD   = 2'd2
  } wbu_state_e;

  typedef struct packed {
    logic wen;
    logic csr_wen;
    logic brch;
    logic jal;
    logic jalr;
    logic mret;
    logic ecall;
  } wbu_flags_t;

endpackage

// File: rtl/ysyx_23060124_wbu_pcsel.sv
// Next-PC selection for the write-back unit (purely combinational).
// Priority: ecall, mret, jal, jalr, taken branch, sequential.
module ysyx_23060124_wbu_pcsel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] mtvec,
  input  logic            brch_taken,
  input  logic            jal,
  input  logic            jalr,
  input  logic            mret,
  input  logic            ecall,
  output logic [XLEN-1:0] pc_next
);

  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] rs1_imm;
  logic [XLEN-1:0] pc_seq;

  assign pc_imm  = pc + imm;
  assign rs1_imm = rs1 + imm;
  assign pc_seq  = pc + XLEN'(4);

  always_comb begin
    pc_next = pc_seq;
    if (ecall)           pc_next = mtvec;
    else if (mret)       pc_next = mepc;
    else if (jal)        pc_next = pc_imm;
    else if (jalr)       pc_next = {rs1_imm[XLEN-1:1], 1'b0};
    else if (brch_taken) pc_next = pc_imm;
  end

endmodule

// File: rtl/ysyx_23060124_wbu.sv
// Write-back unit: commits regfile/CSR writes and redirects the IFU.
// Define YSYX_23060124_WBU_PERF_EN to add a 64-bit retired counter.
module ysyx_23060124_wbu
  import ysyx_23060124_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_res,
  input  logic [XLEN-1:0] i_mepc,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [4:0]      i_rd,
  input  logic [11:0]     i_csr_addr,
  input  logic            i_wen,
  input  logic            i_csr_wen,
  input  logic            i_brch,
  input  logic            i_jal,
  input  logic            i_jalr,
  input  logic            i_mret,
  input  logic            i_ecall,
  output logic            o_rf_wen,
  output logic [4:0]      o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic            o_csr_wen,
  output logic [11:0]     o_csr_waddr,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic            o_csr_ecall,
  output logic            o_pc_valid,
  input  logic            i_pc_ready,
  output logic [XLEN-1:0] o_pc_next,
`ifdef YSYX_23060124_WBU_PERF_EN
  output logic [63:0]     o_perf_retired,
`endif
  output logic            o_retire
);

  wbu_state_e      state_q, state_d;
  wbu_flags_t      flg_q;
  logic            boot_q;
  logic [XLEN-1:0] pc_q, imm_q, rs1_q, res_q, mepc_q, mtvec_q;
  logic [4:0]      rd_q;
  logic [11:0]     csr_q;
  logic [XLEN-1:0] sel_pc;
  logic            accept;
  logic            commit;

  // Outputs are gated by reset so nothing escapes during a reset cycle.
  assign commit   = reset && state_q == S_COMMIT;
  assign in_ready = reset && !boot_q && state_q == S_IDLE;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_COMMIT;
      S_COMMIT: state_d = i_pc_ready ? S_IDLE : S_HOLD;
      S_HOLD:   if (i_pc_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      boot_q  <= 1'b1;
      flg_q   <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      res_q   <= '0;
      mepc_q  <= '0;
      mtvec_q <= '0;
      rd_q    <= '0;
      csr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (boot_q && i_pc_ready) boot_q <= 1'b0;
      if (accept) begin
        flg_q   <= '{i_wen, i_csr_wen, i_brch, i_jal,
                     i_jalr, i_mret, i_ecall};
        pc_q    <= i_pc;
        imm_q   <= i_imm;
        rs1_q   <= i_rs1;
        res_q   <= i_res;
        mepc_q  <= i_mepc;
        mtvec_q <= i_mtvec;
        rd_q    <= i_rd;
        csr_q   <= i_csr_addr;
      end
    end
  end

  ysyx_23060124_wbu_pcsel #(
    .XLEN(XLEN)
  ) u_pcsel (
    .pc        (pc_q),
    .imm       (imm_q),
    .rs1       (rs1_q),
    .mepc      (mepc_q),
    .mtvec     (mtvec_q),
    .brch_taken(flg_q.brch && res_q[0]),
    .jal       (flg_q.jal),
    .jalr      (flg_q.jalr),
    .mret      (flg_q.mret),
    .ecall     (flg_q.ecall),
    .pc_next   (sel_pc)
  );

  assign o_rf_wen    = commit && flg_q.wen && rd_q != 5'd0;
  assign o_rf_waddr  = rd_q;
  assign o_rf_wdata  = (flg_q.jal || flg_q.jalr) ? pc_q + XLEN'(4)
                                                 : res_q;
  assign o_csr_wen   = commit && flg_q.csr_wen;
  assign o_csr_waddr = csr_q;
  assign o_csr_ecall = commit && flg_q.ecall;
  assign o_csr_wdata = flg_q.ecall ? pc_q : res_q;
  assign o_retire    = commit;

  // Boot handshake hands the IFU its reset vector before any commit.
  assign o_pc_valid = reset && (boot_q || state_q != S_IDLE);
  assign o_pc_next  = (!reset || boot_q) ? RESET_PC : sel_pc;

`ifdef YSYX_23060124_WBU_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset)        o_perf_retired <= '0;
    else if (o_retire) o_perf_retired <= o_perf_retired + 64'd1;
  end
`endif

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// Self-checking bench for ysyx_23060124_wbu: directed cases plus
// randomized instructions checked against a next-PC/write model.
module tb_ysyx_23060124_wbu;

  localparam logic [31:0] RPC = 32'h3000_0000;

  typedef struct {
    logic [31:0] pc, imm, rs1, res, mepc, mtvec;
    logic [4:0]  rd;
    logic [11:0] csr;
    bit wen, csr_wen, brch, jal, jalr, mret, ecall;
  } ins_t;

  logic        clock = 0;
  logic        reset = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] i_pc = 0, i_imm = 0, i_rs1 = 0, i_res = 0;
  logic [31:0] i_mepc = 0, i_mtvec = 0;
  logic [4:0]  i_rd = 0;
  logic [11:0] i_csr_addr = 0;
  logic        i_wen = 0, i_csr_wen = 0, i_brch = 0, i_jal = 0;
  logic        i_jalr = 0, i_mret = 0, i_ecall = 0;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic        o_csr_wen;
  logic [11:0] o_csr_waddr;
  logic [31:0] o_csr_wdata;
  logic        o_csr_ecall;
  logic        o_pc_valid;
  logic        i_pc_ready = 1;
  logic [31:0] o_pc_next;
  logic        o_retire;

  int n_assert = 0;
  int n_fail   = 0;
  int rf_writes = 0;
  int retires   = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (o_rf_wen) rf_writes++;
    if (o_retire) retires++;
  end

  ysyx_23060124_wbu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .i_pc(i_pc), .i_imm(i_imm), .i_rs1(i_rs1), .i_res(i_res),
    .i_mepc(i_mepc), .i_mtvec(i_mtvec),
    .i_rd(i_rd), .i_csr_addr(i_csr_addr),
    .i_wen(i_wen), .i_csr_wen(i_csr_wen), .i_brch(i_brch),
    .i_jal(i_jal), .i_jalr(i_jalr), .i_mret(i_mret),
    .i_ecall(i_ecall),
    .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr),
    .o_rf_wdata(o_rf_wdata),
    .o_csr_wen(o_csr_wen), .o_csr_waddr(o_csr_waddr),
    .o_csr_wdata(o_csr_wdata), .o_csr_ecall(o_csr_ecall),
    .o_pc_valid(o_pc_valid), .i_pc_ready(i_pc_ready),
    .o_pc_next(o_pc_next), .o_retire(o_retire)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input ins_t t);
    if (t.ecall) return t.mtvec;
    if (t.mret)  return t.mepc;
    if (t.jal)   return t.pc + t.imm;
    if (t.jalr)  return (t.rs1 + t.imm) & ~32'h1;
    if (t.brch && t.res[0]) return t.pc + t.imm;
    return t.pc + 32'd4;
  endfunction

  function automatic ins_t blank();
    ins_t t;
    t.pc = 0; t.imm = 0; t.rs1 = 0; t.res = 0;
    t.mepc = 0; t.mtvec = 0; t.rd = 0; t.csr = 0;
    t.wen = 0; t.csr_wen = 0; t.brch = 0; t.jal = 0;
    t.jalr = 0; t.mret = 0; t.ecall = 0;
    return t;
  endfunction

  task automatic drive(input ins_t t);
    i_pc = t.pc; i_imm = t.imm; i_rs1 = t.rs1; i_res = t.res;
    i_mepc = t.mepc; i_mtvec = t.mtvec; i_rd = t.rd;
    i_csr_addr = t.csr; i_wen = t.wen; i_csr_wen = t.csr_wen;
    i_brch = t.brch; i_jal = t.jal; i_jalr = t.jalr;
    i_mret = t.mret; i_ecall = t.ecall;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic run(input string tag, input ins_t t, input int stall);
    logic        exp_w;
    logic [31:0] exp_pc, exp_d;
    int          w0, r0;
    exp_w  = t.wen && t.rd != 0;
    exp_pc = ref_next(t);
    exp_d  = (t.jal || t.jalr) ? t.pc + 32'd4 : t.res;
    w0 = rf_writes; r0 = retires;
    chk({tag, ".in_ready"}, in_ready, 1);
    drive(t);
    in_valid = 1;
    i_pc_ready = (stall == 0);
    @(posedge clock); @(negedge clock);
    in_valid = 0;
    chk({tag, ".rf_wen"}, o_rf_wen, exp_w);
    if (exp_w) begin
      chk({tag, ".rf_waddr"}, o_rf_waddr, t.rd);
      chk({tag, ".rf_wdata"}, o_rf_wdata, exp_d);
    end
    chk({tag, ".csr_wen"}, o_csr_wen, t.csr_wen);
    chk({tag, ".csr_ecall"}, o_csr_ecall, t.ecall);
    if (t.csr_wen) chk({tag, ".csr_waddr"}, o_csr_waddr, t.csr);
    if (t.csr_wen || t.ecall)
      chk({tag, ".csr_wdata"}, o_csr_wdata,
          t.ecall ? t.pc : t.res);
    chk({tag, ".pc_valid"}, o_pc_valid, 1);
    chk({tag, ".pc_next"}, o_pc_next, exp_pc);
    chk({tag, ".retire"}, o_retire, 1);
    chk({tag, ".busy"}, in_ready, 0);
    for (int s = 1; s <= stall; s++) begin
      @(posedge clock); @(negedge clock);
      chk({tag, ".hold_valid"}, o_pc_valid, 1);
      chk({tag, ".hold_pc"}, o_pc_next, exp_pc);
      chk({tag, ".hold_wen"},
          {o_rf_wen, o_csr_wen, o_csr_ecall, o_retire}, 0);
      chk({tag, ".hold_ready"}, in_ready, 0);
      if (s == stall) i_pc_ready = 1;
    end
    @(posedge clock); @(negedge clock);
    chk({tag, ".idle_ready"}, in_ready, 1);
    chk({tag, ".idle_valid"}, o_pc_valid, 0);
    chk({tag, ".n_writes"}, rf_writes - w0, exp_w);
    chk({tag, ".n_retire"}, retires - r0, 1);
  endtask

  initial begin
    ins_t t;
    int   w0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst.pc_valid", o_pc_valid, 0);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.enables",
        {o_rf_wen, o_csr_wen, o_csr_ecall, o_retire}, 0);
    chk("rst.pc_next", o_pc_next, RPC);

    // Boot handshake, held off one cycle
    i_pc_ready = 0;
    reset = 1;
    #1;
    chk("boot.valid", o_pc_valid, 1);
    chk("boot.pc", o_pc_next, RPC);
    chk("boot.ready", in_ready, 0);
    @(posedge clock); @(negedge clock);
    chk("boot.hold_valid", o_pc_valid, 1);
    chk("boot.hold_pc", o_pc_next, RPC);
    i_pc_ready = 1;
    @(posedge clock); @(negedge clock);
    chk("boot.done_valid", o_pc_valid, 0);

    t = blank(); t.pc = 32'h100; t.wen = 1; t.rd = 5;
    t.res = 32'hDEAD;
    run("alu", t, 0);

    t = blank(); t.pc = 32'h80; t.rs1 = 32'h2001; t.imm = 4;
    t.rd = 1; t.wen = 1; t.jalr = 1;
    run("jalr", t, 0);

    t = blank(); t.pc = 32'h200; t.imm = 32'hFFFF_FFF8;
    t.brch = 1; t.res = 1;
    run("br_taken", t, 0);
    t.res = 0;
    run("br_not", t, 0);

    t = blank(); t.pc = 32'h300; t.wen = 1; t.rd = 9;
    t.res = 32'h1234; t.jal = 1; t.imm = 32'h40;
    run("bp", t, 3);

    t = blank(); t.pc = 32'h50; t.mtvec = 32'h400; t.ecall = 1;
    run("ecall", t, 0);

    t = blank(); t.pc = 32'h60; t.wen = 1; t.rd = 0;
    t.res = 32'h77;
    run("rd0", t, 0);

    t = blank(); t.pc = 32'h70; t.csr_wen = 1; t.csr = 12'h341;
    t.res = 32'hABCD; t.mret = 1; t.mepc = 32'h888;
    run("mret", t, 1);

    t = blank(); t.pc = 32'hFFFF_FFFC; t.wen = 1; t.rd = 3;
    t.jal = 1; t.imm = 32'h8;
    run("wrap", t, 0);

    for (int k = 0; k < 40; k++) begin
      t.pc = $urandom & ~32'h3; t.imm = $urandom;
      t.rs1 = $urandom; t.res = $urandom;
      t.mepc = $urandom; t.mtvec = $urandom;
      t.rd = 5'($urandom); t.csr = 12'($urandom);
      t.wen = $urandom_range(0, 1) == 1;
      t.csr_wen = $urandom_range(0, 3) == 0;
      t.brch = $urandom_range(0, 2) == 0;
      t.jal = $urandom_range(0, 4) == 0;
      t.jalr = $urandom_range(0, 4) == 0;
      t.mret = $urandom_range(0, 6) == 0;
      t.ecall = $urandom_range(0, 6) == 0;
      run("rnd", t, int'($urandom_range(0, 2)));
    end

    // Reset while holding a redirect
    t = blank(); t.pc = 32'h500; t.wen = 1; t.rd = 7;
    t.res = 32'h55;
    drive(t);
    in_valid = 1;
    i_pc_ready = 0;
    @(posedge clock); @(negedge clock);
    in_valid = 0;
    @(posedge clock); @(negedge clock);
    chk("rh.in_hold", o_pc_next, 32'h504);
    w0 = rf_writes;
    reset = 0;
    #1;
    chk("rh.valid", o_pc_valid, 0);
    chk("rh.enables",
        {o_rf_wen, o_csr_wen, o_csr_ecall, o_retire}, 0);
    chk("rh.pc", o_pc_next, RPC);
    @(posedge clock); @(negedge clock);
    reset = 1;
    #1;
    chk("rh.boot_valid", o_pc_valid, 1);
    chk("rh.boot_pc", o_pc_next, RPC);
    chk("rh.boot_ready", in_ready, 0);
    i_pc_ready = 1;
    @(posedge clock); @(negedge clock);
    chk("rh.idle", in_ready, 1);
    chk("rh.no_write", rf_writes - w0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
